// File: rtl/wb_cmd_initiator.sv
// Wishbone single-transfer initiator: turns a valid/ready command stream into WBs_* bus
// cycles bounded by an ACK timeout, and returns read data/status on a response stream.
module wb_cmd_initiator #(
   parameter int unsigned ADDRWIDTH      = 17,
   parameter int unsigned DATAWIDTH      = 32,
   parameter int unsigned CNTR_WIDTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 15,
   parameter logic [DATAWIDTH-1:0] DEFAULT_READ_VALUE = 'hBADFABAC
) (
   input  logic                 WB_CLK,
   input  logic                 WB_RST,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_we,
   input  logic [ADDRWIDTH-1:0] cmd_adr,
   input  logic [3:0]           cmd_byte_stb,
   input  logic [DATAWIDTH-1:0] cmd_wdat,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DATAWIDTH-1:0] rsp_rdat,
   output logic                 rsp_err,
   output logic [ADDRWIDTH-1:0] WBs_ADR,
   output logic                 WBs_CYC,
   output logic                 WBs_STB,
   output logic                 WBs_WE,
   output logic                 WBs_RD,
   output logic [3:0]           WBs_BYTE_STB,
   output logic [DATAWIDTH-1:0] WBs_WR_DAT,
   input  logic [DATAWIDTH-1:0] WBs_RD_DAT,
   input  logic                 WBs_ACK,
   output logic                 busy_o,
   output logic [7:0]           timeout_cnt_o
);

   localparam logic [CNTR_WIDTH-1:0] TimeoutLast = CNTR_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

   state_e                 state_q;
   logic                   cmd_ready_q;
   logic                   rsp_valid_q;
   logic [DATAWIDTH-1:0]   rsp_rdat_q;
   logic                   rsp_err_q;
   logic [ADDRWIDTH-1:0]   adr_q;
   logic                   cyc_q;
   logic                   stb_q;
   logic                   we_q;
   logic                   rd_q;
   logic [3:0]             byte_stb_q;
   logic [DATAWIDTH-1:0]   wr_dat_q;
   logic                   busy_q;
   logic [CNTR_WIDTH-1:0]  cnt_q;
   logic [7:0]             to_cnt_q;

   // Low address bits are dropped: the bus carries word-aligned byte addresses only.
   logic unused_adr_lsb;
   assign unused_adr_lsb = ^cmd_adr[1:0];

   always_ff @(posedge WB_CLK) begin
      if (WB_RST) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdat_q  <= '0;
         rsp_err_q   <= 1'b0;
         adr_q       <= '0;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         rd_q        <= 1'b0;
         byte_stb_q  <= '0;
         wr_dat_q    <= '0;
         busy_q      <= 1'b0;
         cnt_q       <= '0;
         to_cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_valid) begin
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_byte_stb != 4'h0) begin
                     adr_q      <= {cmd_adr[ADDRWIDTH-1:2], 2'b00};
                     byte_stb_q <= cmd_byte_stb;
                     wr_dat_q   <= cmd_we ? cmd_wdat : '0;
                     we_q       <= cmd_we;
                     rd_q       <= ~cmd_we;
                     cyc_q      <= 1'b1;
                     stb_q      <= 1'b1;
                     cnt_q      <= '0;
                     state_q    <= StBus;
                  end else begin
                     // No lanes enabled: reject without touching the bus.
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdat_q  <= DEFAULT_READ_VALUE;
                     state_q     <= StResp;
                  end
               end
            end
            StBus: begin
               if (WBs_ACK) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  we_q        <= 1'b0;
                  rd_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdat_q  <= we_q ? '0 : WBs_RD_DAT;
                  state_q     <= StResp;
               end else if (cnt_q == TimeoutLast) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  we_q        <= 1'b0;
                  rd_q        <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdat_q  <= DEFAULT_READ_VALUE;
                  if (to_cnt_q != 8'hFF) begin
                     to_cnt_q <= to_cnt_q + 8'd1;
                  end
                  state_q     <= StResp;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign cmd_ready     = cmd_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdat      = rsp_rdat_q;
   assign rsp_err       = rsp_err_q;
   assign WBs_ADR       = adr_q;
   assign WBs_CYC       = cyc_q;
   assign WBs_STB       = stb_q;
   assign WBs_WE        = we_q;
   assign WBs_RD        = rd_q;
   assign WBs_BYTE_STB  = byte_stb_q;
   assign WBs_WR_DAT    = wr_dat_q;
   assign busy_o        = busy_q;
   assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Randomised scoreboard bench for wb_cmd_initiator: a behavioural client and reference model
// predict bus cycles and responses; independent monitors compare what the DUT presents.
module tb_wb_cmd_initiator;

   localparam int          T   = 15;
   localparam logic [31:0] DEF = 32'hBADFABAC;

   logic        WB_CLK = 1'b0;
   logic        WB_RST = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [16:0] cmd_adr = '0;
   logic [3:0]  cmd_byte_stb = '0;
   logic [31:0] cmd_wdat = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdat;
   logic        rsp_err;
   logic [16:0] WBs_ADR;
   logic        WBs_CYC, WBs_STB, WBs_WE, WBs_RD;
   logic [3:0]  WBs_BYTE_STB;
   logic [31:0] WBs_WR_DAT;
   logic [31:0] WBs_RD_DAT;
   logic        WBs_ACK = 1'b0;
   logic        busy_o;
   logic [7:0]  timeout_cnt_o;

   wb_cmd_initiator dut (
      .WB_CLK        (WB_CLK),
      .WB_RST        (WB_RST),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_we        (cmd_we),
      .cmd_adr       (cmd_adr),
      .cmd_byte_stb  (cmd_byte_stb),
      .cmd_wdat      (cmd_wdat),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_rdat      (rsp_rdat),
      .rsp_err       (rsp_err),
      .WBs_ADR       (WBs_ADR),
      .WBs_CYC       (WBs_CYC),
      .WBs_STB       (WBs_STB),
      .WBs_WE        (WBs_WE),
      .WBs_RD        (WBs_RD),
      .WBs_BYTE_STB  (WBs_BYTE_STB),
      .WBs_WR_DAT    (WBs_WR_DAT),
      .WBs_RD_DAT    (WBs_RD_DAT),
      .WBs_ACK       (WBs_ACK),
      .busy_o        (busy_o),
      .timeout_cnt_o (timeout_cnt_o)
   );

   always #5 WB_CLK = ~WB_CLK;

   typedef struct { logic [31:0] rdat; logic err; logic [7:0] tocnt; } rsp_t;
   typedef struct { logic [16:0] adr; logic we; logic [3:0] bstb; logic [31:0] wdat; int len; } bus_t;

   rsp_t rq[$];
   bus_t bq[$];

   int n_chk  = 0;
   int n_pass = 0;

   int          cur_waits = 0;
   logic [31:0] cur_rdata = '0;
   bit          spurious  = 0;
   bit          abort     = 0;
   int          rdy_mode  = 0;   // 0: always ready, 1: random, 2: held low
   int          model_to  = 0;

   assign WBs_RD_DAT = cur_rdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic expire(input string name);
      n_chk++;
      $display("FAIL %s: bound expired or unexpected event", name);
   endtask

   // Reference model: response and bus cycle follow from wait states vs the timeout bound.
   task automatic issue(input logic we, input logic [16:0] adr, input logic [3:0] bstb,
                        input logic [31:0] wdat, input int waits, input logic [31:0] rdata);
      int   g = 0;
      rsp_t r;
      bus_t b;
      bit   timed_out;
      @(negedge WB_CLK);
      while (!cmd_ready && g < 2000) begin
         @(negedge WB_CLK);
         g++;
      end
      if (!cmd_ready) begin
         expire("cmd_ready_wait");
         return;
      end
      cur_waits    = waits;
      cur_rdata    = rdata;
      cmd_valid    = 1'b1;
      cmd_we       = we;
      cmd_adr      = adr;
      cmd_byte_stb = bstb;
      cmd_wdat     = wdat;
      timed_out    = (bstb != 0) && (waits >= T);
      if (timed_out && model_to < 255) model_to++;
      if (bstb != 0) begin
         b.adr  = {adr[16:2], 2'b00};
         b.we   = we;
         b.bstb = bstb;
         b.wdat = we ? wdat : 32'h0;
         b.len  = timed_out ? T : waits + 1;
         bq.push_back(b);
      end
      r.err   = (bstb == 0) || timed_out;
      r.rdat  = r.err ? DEF : (we ? 32'h0 : rdata);
      r.tocnt = 8'(model_to);
      rq.push_back(r);
      @(negedge WB_CLK);
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((rq.size() != 0 || busy_o) && g < 2000) begin
         @(negedge WB_CLK);
         g++;
      end
      if (rq.size() != 0 || busy_o) expire("drain");
   endtask

   // Client: ACK in the (waits+1)th cycle of CYC; optional spurious ACK while idle.
   int cyc_n = 0;
   always @(negedge WB_CLK) begin
      if (WBs_CYC) cyc_n++;
      else cyc_n = 0;
      WBs_ACK = (WBs_CYC && cyc_n == cur_waits + 1) || (!WBs_CYC && spurious);
   end

   always @(posedge WB_CLK) begin
      #2;
      case (rdy_mode)
         0:       rsp_ready = 1'b1;
         1:       rsp_ready = ($urandom_range(0, 3) != 0);
         default: rsp_ready = 1'b0;
      endcase
   end

   bus_t be;
   int   blen = 0;
   bit   prev_cyc = 0;
   always @(negedge WB_CLK) begin
      if (abort) begin
         prev_cyc = 0;
         blen     = 0;
      end else begin
         if (WBs_CYC) begin
            if (!prev_cyc) begin
               if (bq.size() == 0) expire("bus_unexpected_cyc");
               else be = bq.pop_front();
               blen = 0;
            end
            blen++;
            chk("bus_adr", 64'(WBs_ADR), 64'(be.adr));
            chk("bus_stb", 64'(WBs_STB), 64'd1);
            chk("bus_we", 64'(WBs_WE), 64'(be.we));
            chk("bus_rd", 64'(WBs_RD), 64'(!be.we));
            chk("bus_bstb", 64'(WBs_BYTE_STB), 64'(be.bstb));
            chk("bus_wdat", 64'(WBs_WR_DAT), 64'(be.wdat));
         end else if (prev_cyc) begin
            chk("bus_len", 64'(blen), 64'(be.len));
         end
         prev_cyc = WBs_CYC;
      end
   end

   always @(negedge WB_CLK) begin
      if (!abort && rsp_valid) begin
         if (rq.size() == 0) begin
            expire("rsp_unexpected");
         end else begin
            chk("rsp_rdat", 64'(rsp_rdat), 64'(rq[0].rdat));
            chk("rsp_err", 64'(rsp_err), 64'(rq[0].err));
            chk("rsp_tocnt", 64'(timeout_cnt_o), 64'(rq[0].tocnt));
            chk("rsp_cmd_ready", 64'(cmd_ready), 64'd0);
            chk("rsp_cyc", 64'(WBs_CYC), 64'd0);
            chk("rsp_busy", 64'(busy_o), 64'd1);
            if (rsp_ready) void'(rq.pop_front());
         end
      end
   end

   initial begin
      repeat (3) @(negedge WB_CLK);
      WB_RST = 1'b0;
      @(negedge WB_CLK);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_cyc", 64'(WBs_CYC), 64'd0);
      chk("rst_adr", 64'(WBs_ADR), 64'd0);
      chk("rst_tocnt", 64'(timeout_cnt_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);

      issue(1'b1, 17'h01004, 4'hF, 32'h12345678, 0, 32'h0);
      issue(1'b0, 17'h00007, 4'hF, 32'h0, 3, 32'hA5A50001);
      issue(1'b0, 17'h00100, 4'hF, 32'h0, 1000, 32'h11111111);
      issue(1'b0, 17'h00200, 4'h3, 32'h0, T - 1, 32'h22222222);
      issue(1'b1, 17'h00300, 4'h0, 32'hDEADBEEF, 0, 32'h0);
      drain();

      rdy_mode = 2;
      issue(1'b0, 17'h00404, 4'hC, 32'h0, 2, 32'h5A5A5A5A);
      repeat (4) @(negedge WB_CLK);
      spurious = 1;
      repeat (10) @(negedge WB_CLK);
      spurious = 0;
      @(negedge WB_CLK);
      chk("bp_no_new_cyc", 64'(WBs_CYC), 64'd0);
      rdy_mode = 0;
      drain();

      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         int w;
         case ($urandom_range(0, 5))
            0:       w = T - 1;
            1:       w = T;
            default: w = $urandom_range(0, 5);
         endcase
         issue(1'($urandom_range(0, 1)), 17'($urandom), 4'($urandom_range(0, 15)),
               $urandom, w, $urandom);
      end
      drain();

      rdy_mode = 0;
      for (int i = 0; i < 300; i++) begin
         issue(1'($urandom_range(0, 1)), 17'($urandom), 4'($urandom_range(1, 15)),
               $urandom, 1000, $urandom);
      end
      drain();
      chk("tocnt_saturated", 64'(timeout_cnt_o), 64'd255);

      issue(1'b0, 17'h00808, 4'hF, 32'h0, 10, 32'h33333333);
      abort = 1;
      @(negedge WB_CLK);
      WB_RST = 1'b1;
      @(negedge WB_CLK);
      WB_RST = 1'b0;
      chk("midrst_cyc", 64'(WBs_CYC), 64'd0);
      chk("midrst_stb", 64'(WBs_STB), 64'd0);
      chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_tocnt", 64'(timeout_cnt_o), 64'd0);
      @(negedge WB_CLK);
      rq.delete();
      bq.delete();
      model_to = 0;
      abort = 0;
      issue(1'b0, 17'h0080B, 4'hF, 32'h0, 1, 32'hCAFEF00D);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
